// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: core has priority with zero-latency passthrough, aux requests wait in IDLE/PEND FSM.
// Optional starvation guard enabled by defining DMEM_ARB_STARVE_GUARD_EN.
module dmem_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 30,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_rd_en,
  input  logic                  core_wr_en,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic [DATA_WIDTH-1:0] core_rdata,
  output logic                  core_stall,
  input  logic                  aux_req,
  input  logic                  aux_we,
  input  logic [ADDR_WIDTH-1:0] aux_addr,
  input  logic [DATA_WIDTH-1:0] aux_wdata,
  output logic                  aux_ready,
  output logic                  aux_done,
  output logic [DATA_WIDTH-1:0] aux_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_w_en,
  output logic                  mem_read_en,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  typedef enum logic {IDLE, PEND} state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  core_access, aux_own, force_aux;

  assign core_access = core_rd_en | core_wr_en;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] wait_q, wait_d;

  assign force_aux = (state_q == PEND) & core_access & ~reset & (wait_q == CW'(STARVE_LIMIT));

  always_comb begin
    wait_d = wait_q;
    if (state_q == IDLE) begin
      if (aux_req) wait_d = '0;
    end else if (aux_own) begin
      wait_d = '0;
    end else if (wait_q != CW'(STARVE_LIMIT)) begin
      wait_d = wait_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wait_q <= '0;
    else       wait_q <= wait_d;
  end
`else
  assign force_aux = 1'b0;
`endif

  assign aux_own = (state_q == PEND) & ~reset & (~core_access | force_aux);

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (aux_req) begin
        we_d    = aux_we;
        addr_d  = aux_addr;
        wdata_d = aux_wdata;
        state_d = PEND;
      end
      PEND: if (aux_own) begin
        done_d  = 1'b1;
        if (!we_q) rdata_d = mem_rdata;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  // A stalled core request never reaches memory: the aux op owns the port that cycle.
  assign mem_addr    = aux_own ? addr_q  : core_addr;
  assign mem_wdata   = aux_own ? wdata_q : core_wdata;
  assign mem_w_en    = aux_own ? we_q    : core_wr_en;
  assign mem_read_en = aux_own ? ~we_q   : core_rd_en;

  assign core_rdata = mem_rdata;
  assign core_stall = force_aux;
  assign aux_ready  = (state_q == IDLE) & ~reset;
  assign aux_done   = done_q;
  assign aux_rdata  = rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a transaction-level model of the arbiter and memory.
module tb_dmem_arbiter;
  localparam int DW = 32, AW = 30, LIM = 8;
`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b1;
  logic core_rd_en = 0, core_wr_en = 0, aux_req = 0, aux_we = 0;
  logic [AW-1:0] core_addr = '0, aux_addr = '0;
  logic [DW-1:0] core_wdata = '0, aux_wdata = '0;
  logic [DW-1:0] core_rdata, aux_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic core_stall, aux_ready, aux_done, mem_w_en, mem_read_en;

  int n_chk = 0, n_err = 0;
  logic [DW-1:0] dmem [64];
  logic [DW-1:0] ref_mem [64];

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .core_rd_en(core_rd_en), .core_wr_en(core_wr_en), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_ready(aux_ready), .aux_done(aux_done), .aux_rdata(aux_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_w_en(mem_w_en),
    .mem_read_en(mem_read_en), .mem_rdata(mem_rdata));

  // Single-port memory with combinational read
  assign mem_rdata = dmem[mem_addr[5:0]];
  always @(posedge clk) if (mem_w_en) dmem[mem_addr[5:0]] <= mem_wdata;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: one optional pending aux transaction, its wait age, and last completion.
  bit            m_pend = 0, m_we = 0, m_done = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_rdata = '0;
  int            m_wait = 0;
  bit            e_go, e_force, e_wen, e_ren;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;

  always @(negedge clk) begin
    if (reset) begin
      m_pend = 0; m_wait = 0; m_done = 0; m_rdata = '0;
    end
    e_force = !reset && GUARD && m_pend && (core_rd_en || core_wr_en) && (m_wait >= LIM);
    e_go    = !reset && m_pend && (!(core_rd_en || core_wr_en) || e_force);
    e_addr  = e_go ? m_addr  : core_addr;
    e_wdata = e_go ? m_wdata : core_wdata;
    e_wen   = e_go ? m_we    : core_wr_en;
    e_ren   = e_go ? !m_we   : core_rd_en;
    chk("aux_ready", aux_ready, !reset && !m_pend);
    chk("aux_done", aux_done, m_done);
    chk("aux_rdata", aux_rdata, m_rdata);
    chk("core_stall", core_stall, e_force);
    chk("mem_w_en", mem_w_en, e_wen);
    chk("mem_read_en", mem_read_en, e_ren);
    if (e_wen || e_ren) chk("mem_addr", mem_addr, e_addr);
    if (e_wen) chk("mem_wdata", mem_wdata, e_wdata);
    if (core_rd_en && !e_go) chk("core_rdata", core_rdata, ref_mem[core_addr[5:0]]);
    // advance to the state after the coming rising edge
    m_done = e_go;
    if (e_go && !m_we) m_rdata = ref_mem[m_addr[5:0]];
    if (e_wen) ref_mem[e_addr[5:0]] = e_wdata;
    if (!reset) begin
      if (e_go) begin
        m_pend = 0; m_wait = 0;
      end else if (m_pend) begin
        if (m_wait < LIM) m_wait++;
      end else if (aux_req) begin
        m_pend = 1; m_wait = 0; m_we = aux_we; m_addr = aux_addr; m_wdata = aux_wdata;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic core_idle();
    core_rd_en = 0; core_wr_en = 0;
  endtask

  initial begin
    logic [AW-1:0] b2b_addr [4];
    logic [DW-1:0] b2b_data [4];
    int stall_cyc, done_cyc;
    bit stall_seen;
    for (int i = 0; i < 64; i++) begin dmem[i] = '0; ref_mem[i] = '0; end

    @(negedge clk);
    chk("rst_ready", aux_ready, 0);
    chk("rst_done", aux_done, 0);
    chk("rst_rdata", aux_rdata, 0);
    step(); reset = 0;

    // core only
    core_wr_en = 1; core_addr = 'h10; core_wdata = 32'hDEADBEEF;
    @(negedge clk); chk("core_wen", mem_w_en, 1);
    step(); core_wr_en = 0; core_rd_en = 1;
    @(negedge clk); chk("core_rd", core_rdata, 32'hDEADBEEF); chk("core_nodone", aux_done, 0);
    step(); core_idle();

    // aux write then read, idle core
    aux_req = 1; aux_we = 1; aux_addr = 'h20; aux_wdata = 32'h12345678;
    @(negedge clk); chk("aw_ready", aux_ready, 1);
    step(); aux_req = 0;
    @(negedge clk); chk("aw_access", mem_w_en, 1); chk("aw_addr", mem_addr, 'h20);
    step();
    @(negedge clk); chk("aw_done", aux_done, 1); chk("aw_ready_done", aux_ready, 1);
    step();
    @(negedge clk); chk("aw_done_pulse", aux_done, 0);
    aux_req = 1; aux_we = 0; aux_addr = 'h20;
    step(); aux_req = 0; step();
    @(negedge clk); chk("ar_done", aux_done, 1); chk("ar_data", aux_rdata, 32'h12345678);
    step();

    // contention: 5 core accesses right after accept
    aux_req = 1; aux_we = 0; aux_addr = 'h10;
    step(); aux_req = 0;
    for (int i = 1; i <= 5; i++) begin
      core_rd_en = 1; core_addr = 'h20;
      @(negedge clk); chk("ct_nostall", core_stall, 0); chk("ct_nodone", aux_done, 0);
      step();
    end
    core_idle(); step();
    @(negedge clk); chk("ct_done7", aux_done, 1); chk("ct_data", aux_rdata, 32'hDEADBEEF);
    step();

    // starvation: continuous core traffic against one aux write
    aux_req = 1; aux_we = 1; aux_addr = 'h30; aux_wdata = 32'hA5A5A5A5;
    step(); aux_req = 0; core_rd_en = 1; core_addr = 'h10;
    stall_cyc = -1; done_cyc = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (core_stall) stall_cyc = (stall_cyc == -1) ? i : 100;
      if (aux_done && done_cyc == -1) done_cyc = i;
      step();
    end
    chk("st_stall_cyc", stall_cyc, GUARD ? 9 : -1);
    chk("st_done_cyc", done_cyc, GUARD ? 10 : -1);
    core_idle(); step(); step(); step();
    chk("st_landed", dmem[6'h30], 32'hA5A5A5A5);

    // reset while an aux write is pending
    aux_req = 1; aux_we = 1; aux_addr = 'h38; aux_wdata = 32'h11111111;
    core_rd_en = 1; core_addr = 'h10;
    step(); aux_req = 0; step(); step();
    reset = 1;
    @(negedge clk); chk("rp_ready_rst", aux_ready, 0);
    step(); reset = 0; core_idle();
    @(negedge clk); chk("rp_ready", aux_ready, 1); chk("rp_nodone", aux_done, 0);
    step();
    @(negedge clk); chk("rp_nodone2", aux_done, 0); chk("rp_mem", dmem[6'h38], 0);
    step();

    // back-to-back aux reads, aux_req held high
    b2b_addr[0] = 'h10; b2b_addr[1] = 'h20; b2b_addr[2] = 'h30; b2b_addr[3] = 'h38;
    b2b_data[0] = 32'hDEADBEEF; b2b_data[1] = 32'h12345678;
    b2b_data[2] = 32'hA5A5A5A5; b2b_data[3] = 32'h0;
    aux_req = 1; aux_we = 0;
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) aux_addr = b2b_addr[i]; else aux_req = 0;
      @(negedge clk);
      if (i > 0) begin chk("bb_done", aux_done, 1); chk("bb_data", aux_rdata, b2b_data[i-1]); end
      step();
      @(negedge clk); chk("bb_gap", aux_done, 0);
      step();
    end

    // randomized traffic; a stalled core holds its request
    stall_seen = 0;
    for (int c = 0; c < 3000; c++) begin
      int p;
      p = ((c / 200) % 2) ? 90 : 30;
      if (!stall_seen) begin
        core_idle();
        if ($urandom_range(99) < p) begin
          if ($urandom_range(1)) core_wr_en = 1; else core_rd_en = 1;
          core_addr = AW'($urandom_range(63)); core_wdata = $urandom;
        end
      end
      aux_req = ($urandom_range(2) == 0);
      aux_we = $urandom_range(1); aux_addr = AW'($urandom_range(63)); aux_wdata = $urandom;
      reset = ($urandom_range(499) == 0);
      @(negedge clk); stall_seen = core_stall;
      step();
    end
    reset = 0; core_idle(); aux_req = 0;
    step(); step(); step();
    for (int i = 0; i < 64; i++) chk("final_mem", dmem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter placed in front of the single-port data memory in the 3-stage core. It shares the memory between the core's execute/memory stage (highest priority, zero added latency) and an auxiliary requester (program loader / debug port) using a ready/done handshake. Aux requests are latched and wait in a small state machine until the core leaves a free cycle. An optional starvation guard stalls the core for one cycle when the aux requester has waited too long.

## Interface
Parameters:
- DATA_WIDTH, 32, memory word width
- ADDR_WIDTH, 30, word address width (byte address [31:2])
- STARVE_LIMIT, 8, wait cycles before a forced aux grant (guard builds only; ≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- core_rd_en  in  1  core memory-stage read
- core_wr_en  in  1  core memory-stage write
- core_addr  in  ADDR_WIDTH  core word address
- core_wdata  in  DATA_WIDTH  core store data
- core_rdata  out  DATA_WIDTH  load data to writeback mux (= mem_rdata)
- core_stall  out  1  hold core memory stage this cycle (guard builds only, else tied 0)
- aux_req  in  1  aux request valid
- aux_we  in  1  aux write (1) / read (0)
- aux_addr  in  ADDR_WIDTH  aux word address
- aux_wdata  in  DATA_WIDTH  aux store data
- aux_ready  out  1  arbiter can accept an aux request
- aux_done  out  1  one-cycle completion pulse
- aux_rdata  out  DATA_WIDTH  aux read data, valid with aux_done
- mem_addr  out  ADDR_WIDTH  to dmem addr
- mem_wdata  out  DATA_WIDTH  to dmem data_in
- mem_w_en  out  1  to dmem w_en
- mem_read_en  out  1  to dmem read_en
- mem_rdata  in  DATA_WIDTH  from dmem data_out (combinational read)

## Operation
- core_access = core_rd_en | core_wr_en. The core path is combinational passthrough: when the core owns the cycle, mem_* = core_* exactly.
- States: IDLE, PEND. aux_ready = (state==IDLE) & ~reset.
- IDLE: aux_req & aux_ready → latch aux_we/addr/wdata, clear wait_cnt, go to PEND. With aux_req low, stay in IDLE.
- PEND, aux owns the cycle when ~core_access (or guard forces it): mem_* driven from the latch, mem_read_en = ~we, mem_w_en = we. At the clock edge, aux_rdata <= mem_rdata (reads only; writes leave aux_rdata unchanged), aux_done <= 1, state → IDLE.
- PEND, core owns the cycle: latch held, wait_cnt increments, saturating at STARVE_LIMIT.
- When no one owns the cycle, mem_w_en = mem_read_en = 0. mem_addr/mem_wdata hold the core values.
- aux_done is registered and lasts exactly one cycle. aux_rdata holds its value until the next aux read completes.
- Aux inputs are sampled only at the accept edge. Changes while in PEND have no effect.

## Timing
- Reset (async): state=IDLE, wait_cnt=0, aux_done=0, aux_rdata=0, aux_ready=0 while reset is high.
- Core latency: 0 added cycles. core_rdata is valid in the same cycle as core_rd_en.
- Aux minimum latency: accept at edge k, access in cycle k+1, aux_done high in cycle k+2. aux_ready is high again in the done cycle, so back-to-back requests sustain one access per 2 cycles.
- Simultaneous core access and aux access in PEND: the core wins (unless the guard fires). The aux request is never dropped.
- Reset during PEND: the pending aux operation is discarded, no aux_done is generated, and no memory write occurs after reset assertion.
- The memory write commits at the rising edge ending the owning cycle.

## Configuration
- DMEM_ARB_STARVE_GUARD_EN defined: in PEND, when wait_cnt == STARVE_LIMIT and core_access, core_stall=1 combinationally and the aux operation owns that cycle. The core must hold its memory-stage request and retry the next cycle. wait_cnt clears on every aux completion.
- Undefined: core_stall is tied 0, wait_cnt logic is omitted, and the aux requester may wait indefinitely under continuous core traffic.

## Test plan
- Core only: core_wr_en addr 0x10 data 0xDEADBEEF, then core_rd_en addr 0x10 → mem_w_en high the same cycle, core_rdata=0xDEADBEEF the same cycle as the read, aux_done stays 0.
- Aux write/read with an idle core: aux write addr 0x20 data 0x12345678, then aux read addr 0x20 → each aux_done comes 2 cycles after accept, aux_rdata=0x12345678, aux_ready is high in each done cycle.
- Contention: aux read accepted while the core issues 5 consecutive accesses → the aux access occurs in the first free cycle, aux_done arrives 7 cycles after accept, and the core sees no stall.
- Starvation (guard built, STARVE_LIMIT=8): continuous core access plus one aux write → core_stall is high for exactly one cycle, 9 cycles after accept, the aux write lands, and the core resumes. In a guard-off build, aux_done never arrives.
- Reset mid-PEND: aux write pending under core traffic, then assert reset for 1 cycle → no aux_done, memory unchanged at the aux address, aux_ready=1 after deassertion.
- Back-to-back: 4 aux reads with aux_req held high and an idle core → aux_done pulses every 2 cycles with the correct data.
